// File: rtl/env_ram_agent_if.sv
// env_ram_agent_if -- bus bundle between env_ram_agent and its two peers:
//   * one port of the host/FPGA shared environment RAM
//       o_ram_wr_n  write strobe, active-low
//       o_ram_addr  word address
//       o_ram_data  write data
//       i_ram_data  registered read data, valid one cycle after the address
//   * the environment core
//       o_act_valid / i_act_ready / o_act_data   action offer
//       o_env_idx                                 current environment index
//       i_res_valid / o_res_ready                 result offer
//       i_obs / i_rwd / i_done                    result payload
// master = agent side, slave = RAM/core side.
interface env_ram_agent_if #(
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned DATA_WIDTH = 48,
  parameter int unsigned OBS_WD_NUM = 3,
  parameter int unsigned ACT_WL     = 32,
  parameter int unsigned RWD_WL     = 32
);
  logic                             o_ram_wr_n;
  logic [ADDR_WIDTH-1:0]            o_ram_addr;
  logic [DATA_WIDTH-1:0]            o_ram_data;
  logic [DATA_WIDTH-1:0]            i_ram_data;
  logic                             o_act_valid;
  logic                             i_act_ready;
  logic [ACT_WL-1:0]                o_act_data;
  logic [7:0]                       o_env_idx;
  logic                             i_res_valid;
  logic                             o_res_ready;
  logic [OBS_WD_NUM*DATA_WIDTH-1:0] i_obs;
  logic [RWD_WL-1:0]                i_rwd;
  logic                             i_done;

  modport master (
    output o_ram_wr_n, o_ram_addr, o_ram_data, o_act_valid, o_act_data,
           o_env_idx, o_res_ready,
    input  i_ram_data, i_act_ready, i_res_valid, i_obs, i_rwd, i_done
  );

  modport slave (
    input  o_ram_wr_n, o_ram_addr, o_ram_data, o_act_valid, o_act_data,
           o_env_idx, o_res_ready,
    output i_ram_data, i_act_ready, i_res_valid, i_obs, i_rwd, i_done
  );
endinterface

// File: rtl/env_ram_agent.sv
// env_ram_agent -- FPGA-side client of the shared environment RAM.
// Polls the host start flag; when nonzero, walks every environment index:
// reads its action word, hands it to the environment core, collects the
// observation/reward/done result and writes it back to the RAM, packing done
// bits DATA_WIDTH per word. Clearing the start flag tells the host the batch
// results are ready.
// Ports:
//   i_clk         clock
//   i_rst         synchronous active-high reset (abandons a running batch)
//   bus           env_ram_agent_if.master: RAM port + core handshakes
//   o_busy        batch in progress
//   o_batch_done  one-cycle pulse after the start flag has been cleared
// Optional build macro ENV_RAM_AGENT_TIMEOUT_EN: a silent core is replaced
// after 65535 cycles by obs=0, reward=all-ones, done=1.
module env_ram_agent #(
  parameter int unsigned ADDR_WIDTH      = 11,
  parameter int unsigned DATA_WIDTH      = 48,
  parameter int unsigned ENV_NUM         = 192,
  parameter int unsigned OBS_WD_NUM      = 3,
  parameter int unsigned ACT_WL          = 32,
  parameter int unsigned RWD_WL          = 32,
  parameter int unsigned ACT_BASE        = 384,
  parameter int unsigned START_FLAG_ADDR = 576,
  parameter int unsigned OBS_BASE        = 577,
  parameter int unsigned RWD_BASE        = 1153,
  parameter int unsigned DONE_BASE       = 1345,
  parameter int unsigned POLL_GAP        = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  env_ram_agent_if.master   bus,
  output logic              o_busy,
  output logic              o_batch_done
);

  localparam int unsigned BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int unsigned K_W    = (OBS_WD_NUM > 1) ? $clog2(OBS_WD_NUM) : 1;
  localparam int unsigned POLL_W = (POLL_GAP > 1) ? $clog2(POLL_GAP + 1) : 1;

  localparam logic [ADDR_WIDTH-1:0] FLAG_A = ADDR_WIDTH'(START_FLAG_ADDR);
  localparam logic [ADDR_WIDTH-1:0] ACT_A  = ADDR_WIDTH'(ACT_BASE);
  localparam logic [ADDR_WIDTH-1:0] OBS_A  = ADDR_WIDTH'(OBS_BASE);
  localparam logic [ADDR_WIDTH-1:0] RWD_A  = ADDR_WIDTH'(RWD_BASE);
  localparam logic [ADDR_WIDTH-1:0] DONE_A = ADDR_WIDTH'(DONE_BASE);

  typedef enum logic [3:0] {
    IDLE, POLL_RD, POLL_CHK, ACT_RD, ACT_LATCH, ISSUE, WAIT_RES,
    WR_OBS, WR_RWD, PACK, WR_DONE, NEXT, CLR_FLAG
  } state_t;

  state_t                           state;
  logic [POLL_W-1:0]                poll_cnt;
  logic [7:0]                       idx;
  logic [BIT_W-1:0]                 bit_pos;   // idx % DATA_WIDTH
  logic [ADDR_WIDTH-1:0]            word_idx;  // idx / DATA_WIDTH
  logic [K_W-1:0]                   obs_k;
  logic [OBS_WD_NUM*DATA_WIDTH-1:0] obs_q;
  logic [RWD_WL-1:0]                rwd_q;
  logic                             done_q;
  logic [DATA_WIDTH-1:0]            done_acc;

  logic                             ram_wr_n;
  logic [ADDR_WIDTH-1:0]            ram_addr;
  logic [DATA_WIDTH-1:0]            ram_data;
  logic                             act_valid;
  logic [ACT_WL-1:0]                act_data;
  logic                             res_ready;

`ifdef ENV_RAM_AGENT_TIMEOUT_EN
  logic [15:0]                      to_cnt;
`endif

  logic                             res_take;
  logic [OBS_WD_NUM*DATA_WIDTH-1:0] res_obs;
  logic [RWD_WL-1:0]                res_rwd;
  logic                             res_done;
  logic [DATA_WIDTH-1:0]            done_acc_nxt;
  logic [K_W-1:0]                   obs_k_inc;
  logic [ADDR_WIDTH-1:0]            obs_env_base;
  logic                             last_env;
  logic                             last_bit;

  // Result source: the core, or the substitute result once the core times out.
  always_comb begin
    res_take = bus.i_res_valid;
    res_obs  = bus.i_obs;
    res_rwd  = bus.i_rwd;
    res_done = bus.i_done;
`ifdef ENV_RAM_AGENT_TIMEOUT_EN
    if (!bus.i_res_valid && to_cnt == 16'hFFFF) begin
      res_take = 1'b1;
      res_obs  = '0;
      res_rwd  = '1;
      res_done = 1'b1;
    end
`endif
  end

  always_comb begin
    done_acc_nxt          = done_acc;
    done_acc_nxt[bit_pos] = done_q;
  end

  assign obs_k_inc    = obs_k + 1'b1;
  assign obs_env_base = OBS_A + ADDR_WIDTH'(idx) * ADDR_WIDTH'(OBS_WD_NUM);
  assign last_env     = (idx == 8'(ENV_NUM - 1));
  assign last_bit     = (bit_pos == BIT_W'(DATA_WIDTH - 1));

  // Outputs are registered: each transition loads the RAM/handshake values
  // that belong to the state being entered.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= IDLE;
      poll_cnt     <= '0;
      idx          <= '0;
      bit_pos      <= '0;
      word_idx     <= '0;
      obs_k        <= '0;
      obs_q        <= '0;
      rwd_q        <= '0;
      done_q       <= 1'b0;
      done_acc     <= '0;
      ram_wr_n     <= 1'b1;
      ram_addr     <= '0;
      ram_data     <= '0;
      act_valid    <= 1'b0;
      act_data     <= '0;
      res_ready    <= 1'b0;
      o_busy       <= 1'b0;
      o_batch_done <= 1'b0;
`ifdef ENV_RAM_AGENT_TIMEOUT_EN
      to_cnt       <= '0;
`endif
    end else begin
      ram_wr_n     <= 1'b1;
      o_batch_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (poll_cnt == POLL_W'(POLL_GAP - 1)) begin
            poll_cnt <= '0;
            ram_addr <= FLAG_A;
            state    <= POLL_RD;
          end else begin
            poll_cnt <= poll_cnt + 1'b1;
          end
        end
        POLL_RD: state <= POLL_CHK;
        POLL_CHK: begin
          if (bus.i_ram_data != '0) begin
            o_busy   <= 1'b1;
            idx      <= '0;
            bit_pos  <= '0;
            word_idx <= '0;
            done_acc <= '0;
            ram_addr <= ACT_A;
            state    <= ACT_RD;
          end else begin
            state <= IDLE;
          end
        end
        ACT_RD: state <= ACT_LATCH;
        ACT_LATCH: begin
          act_data  <= bus.i_ram_data[ACT_WL-1:0];
          act_valid <= 1'b1;
          state     <= ISSUE;
        end
        ISSUE: begin
          if (bus.i_act_ready) begin
            act_valid <= 1'b0;
            res_ready <= 1'b1;
`ifdef ENV_RAM_AGENT_TIMEOUT_EN
            to_cnt    <= '0;
`endif
            state     <= WAIT_RES;
          end
        end
        WAIT_RES: begin
          if (res_take) begin
            obs_q     <= res_obs;
            rwd_q     <= res_rwd;
            done_q    <= res_done;
            res_ready <= 1'b0;
            obs_k     <= '0;
            ram_wr_n  <= 1'b0;
            ram_addr  <= obs_env_base;
            ram_data  <= res_obs[DATA_WIDTH-1:0];
            state     <= WR_OBS;
          end
`ifdef ENV_RAM_AGENT_TIMEOUT_EN
          else begin
            to_cnt <= to_cnt + 16'd1;
          end
`endif
        end
        WR_OBS: begin
          ram_wr_n <= 1'b0;
          if (obs_k == K_W'(OBS_WD_NUM - 1)) begin
            ram_addr <= RWD_A + ADDR_WIDTH'(idx);
            ram_data <= DATA_WIDTH'(rwd_q);
            state    <= WR_RWD;
          end else begin
            obs_k    <= obs_k_inc;
            ram_addr <= obs_env_base + ADDR_WIDTH'(obs_k_inc);
            ram_data <= obs_q[obs_k_inc*DATA_WIDTH +: DATA_WIDTH];
          end
        end
        WR_RWD: state <= PACK;
        PACK: begin
          done_acc <= done_acc_nxt;
          if (last_bit || last_env) begin
            ram_wr_n <= 1'b0;
            ram_addr <= DONE_A + word_idx;
            ram_data <= done_acc_nxt;
            state    <= WR_DONE;
          end else begin
            state <= NEXT;
          end
        end
        WR_DONE: begin
          done_acc <= '0;
          state    <= NEXT;
        end
        NEXT: begin
          if (last_env) begin
            ram_wr_n <= 1'b0;
            ram_addr <= FLAG_A;
            ram_data <= '0;
            state    <= CLR_FLAG;
          end else begin
            idx      <= idx + 8'd1;
            ram_addr <= ACT_A + ADDR_WIDTH'(idx) + ADDR_WIDTH'(1);
            if (last_bit) begin
              bit_pos  <= '0;
              word_idx <= word_idx + 1'b1;
            end else begin
              bit_pos <= bit_pos + 1'b1;
            end
            state <= ACT_RD;
          end
        end
        CLR_FLAG: begin
          o_busy       <= 1'b0;
          o_batch_done <= 1'b1;
          poll_cnt     <= '0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_ram_wr_n  = ram_wr_n;
  assign bus.o_ram_addr  = ram_addr;
  assign bus.o_ram_data  = ram_data;
  assign bus.o_act_valid = act_valid;
  assign bus.o_act_data  = act_data;
  assign bus.o_env_idx   = idx;
  assign bus.o_res_ready = res_ready;

endmodule

// File: tb/tb_env_ram_agent.sv
module tb_env_ram_agent;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_clr = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // DUT A: two environments, core driven by the tasks below
  env_ram_agent_if #(.ADDR_WIDTH(11), .DATA_WIDTH(48), .OBS_WD_NUM(3), .ACT_WL(32), .RWD_WL(32)) ifA ();
  logic busyA, bdA;
  env_ram_agent #(.ENV_NUM(2)) dutA (
    .i_clk(clk), .i_rst(rst), .bus(ifA), .o_busy(busyA), .o_batch_done(bdA));

  // DUT B: fifty environments, core always ready and always done
  env_ram_agent_if #(.ADDR_WIDTH(11), .DATA_WIDTH(48), .OBS_WD_NUM(3), .ACT_WL(32), .RWD_WL(32)) ifB ();
  logic busyB, bdB;
  env_ram_agent #(.ENV_NUM(50)) dutB (
    .i_clk(clk), .i_rst(rst), .bus(ifB), .o_busy(busyB), .o_batch_done(bdB));

  // Dual-port RAM models: agent port + host port
  logic [47:0] memA [0:2047];
  logic [47:0] memB [0:2047];
  logic        hweA = 1'b0, hweB = 1'b0;
  logic [10:0] haddrA, haddrB;
  logic [47:0] hdataA, hdataB;
  int wrA = 0, bdcntA = 0, bdcntB = 0;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 2048; i++) memA[i] <= '0;
    end else begin
      if (!ifA.o_ram_wr_n) begin
        memA[ifA.o_ram_addr] <= ifA.o_ram_data;
        wrA <= wrA + 1;
      end
      if (hweA) memA[haddrA] <= hdataA;
    end
    ifA.i_ram_data <= memA[ifA.o_ram_addr];
    if (bdA) bdcntA <= bdcntA + 1;
  end

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 2048; i++) memB[i] <= '0;
    end else begin
      if (!ifB.o_ram_wr_n) memB[ifB.o_ram_addr] <= ifB.o_ram_data;
      if (hweB) memB[haddrB] <= hdataB;
    end
    ifB.i_ram_data <= memB[ifB.o_ram_addr];
    if (bdB) bdcntB <= bdcntB + 1;
  end

  task automatic host_wr_a(input logic [10:0] a, input logic [47:0] d);
    haddrA = a; hdataA = d; hweA = 1'b1;
    @(negedge clk);
    hweA = 1'b0;
  endtask

  task automatic host_wr_b(input logic [10:0] a, input logic [47:0] d);
    haddrB = a; hdataB = d; hweB = 1'b1;
    @(negedge clk);
    hweB = 1'b0;
  endtask

  // Serve one environment on DUT A: accept its action, return a result,
  // and return at the negedge where the first observation write is driven.
  task automatic serve_env(input logic [31:0] exp_act, input logic [7:0] exp_idx,
                           input logic [143:0] obs, input logic [31:0] rwd, input logic done);
    int n;
    n = 0;
    while (ifA.o_act_valid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (ifA.o_act_valid !== 1'b1) begin
      errors++; $display("FAIL act_valid_wait: got %b, expected 1 within 100 cycles", ifA.o_act_valid);
    end
    checks++;
    if (ifA.o_act_data !== exp_act) begin
      errors++; $display("FAIL act_data: got %h, expected %h", ifA.o_act_data, exp_act);
    end
    checks++;
    if (ifA.o_env_idx !== exp_idx) begin
      errors++; $display("FAIL env_idx: got %0d, expected %0d", ifA.o_env_idx, exp_idx);
    end
    ifA.i_act_ready = 1'b1;
    @(negedge clk);
    ifA.i_act_ready = 1'b0;
    checks++;
    if (ifA.o_res_ready !== 1'b1 || ifA.o_act_valid !== 1'b0) begin
      errors++; $display("FAIL res_ready_after_accept: got ready=%b valid=%b, expected 1/0",
                         ifA.o_res_ready, ifA.o_act_valid);
    end
    ifA.i_res_valid = 1'b1; ifA.i_obs = obs; ifA.i_rwd = rwd; ifA.i_done = done;
    @(negedge clk);
    ifA.i_res_valid = 1'b0;
    checks++;
    if (ifA.o_ram_wr_n !== 1'b0 || ifA.o_ram_addr !== 11'(577 + 3 * exp_idx) ||
        ifA.o_ram_data !== obs[47:0] || ifA.o_res_ready !== 1'b0) begin
      errors++; $display("FAIL obs0_write: got wr_n=%b addr=%0d data=%h ready=%b, expected 0/%0d/%h/0",
                         ifA.o_ram_wr_n, ifA.o_ram_addr, ifA.o_ram_data, ifA.o_res_ready,
                         577 + 3 * exp_idx, obs[47:0]);
    end
  endtask

  task automatic test_reset();
    mem_clr = 1'b1;
    repeat (2) @(negedge clk);
    mem_clr = 1'b0;
    @(negedge clk);
    checks++;
    if (ifA.o_ram_wr_n !== 1'b1 || ifA.o_ram_addr !== 11'd0 || ifA.o_ram_data !== 48'd0 ||
        ifA.o_act_valid !== 1'b0 || ifA.o_res_ready !== 1'b0 || busyA !== 1'b0 || bdA !== 1'b0) begin
      errors++; $display("FAIL reset_values: got wr_n=%b addr=%0d data=%h av=%b rr=%b busy=%b bd=%b, expected 1/0/0/0/0/0/0",
                         ifA.o_ram_wr_n, ifA.o_ram_addr, ifA.o_ram_data, ifA.o_act_valid,
                         ifA.o_res_ready, busyA, bdA);
    end
    checks++;
    if (ifA.o_env_idx !== 8'd0) begin
      errors++; $display("FAIL reset_idx: got %0d, expected 0", ifA.o_env_idx);
    end
    rst = 1'b0;
  endtask

  task automatic test_idle_poll();
    int w0;
    repeat (15) @(negedge clk);
    checks++;
    if (ifA.o_ram_addr !== 11'd0) begin
      errors++; $display("FAIL poll_gap_early: got addr %0d, expected 0", ifA.o_ram_addr);
    end
    @(negedge clk);
    checks++;
    if (ifA.o_ram_addr !== 11'd576) begin
      errors++; $display("FAIL poll_addr: got addr %0d, expected 576", ifA.o_ram_addr);
    end
    w0 = wrA;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      checks++;
      if (busyA !== 1'b0 || ifA.o_act_valid !== 1'b0 || ifA.o_ram_wr_n !== 1'b1) begin
        errors++; $display("FAIL idle_quiet cycle %0d: got busy=%b av=%b wr_n=%b, expected 0/0/1",
                           i, busyA, ifA.o_act_valid, ifA.o_ram_wr_n);
      end
    end
    checks++;
    if (wrA !== w0) begin
      errors++; $display("FAIL idle_writes: got %0d writes, expected 0", wrA - w0);
    end
  endtask

  task automatic test_batch_env0();
    host_wr_a(11'd384, 48'hFFFF_0000_000A);
    host_wr_a(11'd385, 48'h1234_0000_000B);
    host_wr_a(11'd576, 48'd1);
    serve_env(32'hA, 8'd0, {48'd3, 48'd2, 48'd1}, 32'd5, 1'b0);
    checks++;
    if (busyA !== 1'b1) begin
      errors++; $display("FAIL busy_in_batch: got %b, expected 1", busyA);
    end
  endtask

  task automatic test_act_stall();
    int n;
    int w0;
    n = 0;
    while (ifA.o_act_valid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    w0 = wrA;
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (ifA.o_act_valid !== 1'b1 || ifA.o_act_data !== 32'hB) begin
        errors++; $display("FAIL stall_hold cycle %0d: got valid=%b data=%h, expected 1/0000000b",
                           i, ifA.o_act_valid, ifA.o_act_data);
      end
      @(negedge clk);
    end
    checks++;
    if (wrA !== w0) begin
      errors++; $display("FAIL stall_writes: got %0d writes, expected 0", wrA - w0);
    end
  endtask

  task automatic test_batch_finish();
    int n;
    serve_env(32'hB, 8'd1, {48'd6, 48'd5, 48'd4}, 32'd7, 1'b1);
    n = 0;
    while (bdA !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (bdA !== 1'b1) begin
      errors++; $display("FAIL batch_done_wait: got %b, expected 1 within 100 cycles", bdA);
    end
    checks++;
    if (busyA !== 1'b0) begin
      errors++; $display("FAIL busy_after_batch: got %b, expected 0", busyA);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (memA[577] !== 48'd1 || memA[579] !== 48'd3 || memA[580] !== 48'd4 || memA[582] !== 48'd6) begin
      errors++; $display("FAIL obs_words: got %h %h %h %h, expected 1 3 4 6",
                         memA[577], memA[579], memA[580], memA[582]);
    end
    checks++;
    if (memA[1153] !== 48'd5 || memA[1154] !== 48'd7) begin
      errors++; $display("FAIL rwd_words: got %h %h, expected 5 7", memA[1153], memA[1154]);
    end
    checks++;
    if (memA[1345] !== 48'h2 || memA[1346] !== 48'h0) begin
      errors++; $display("FAIL done_word: got %h %h, expected 2 0", memA[1345], memA[1346]);
    end
    checks++;
    if (memA[576] !== 48'd0) begin
      errors++; $display("FAIL flag_cleared: got %h, expected 0", memA[576]);
    end
    checks++;
    if (bdcntA !== 1) begin
      errors++; $display("FAIL batch_done_pulses: got %0d, expected 1", bdcntA);
    end
  endtask

  task automatic test_reset_midbatch();
    int n;
    host_wr_a(11'd576, 48'd1);
    serve_env(32'hA, 8'd0, {48'd3, 48'd2, 48'd1}, 32'd5, 1'b0);
    serve_env(32'hB, 8'd1, {48'd6, 48'd5, 48'd4}, 32'd7, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (ifA.o_ram_wr_n !== 1'b1 || ifA.o_ram_addr !== 11'd0 || ifA.o_ram_data !== 48'd0 ||
        ifA.o_act_valid !== 1'b0 || ifA.o_res_ready !== 1'b0 || busyA !== 1'b0 || ifA.o_env_idx !== 8'd0) begin
      errors++; $display("FAIL midbatch_reset: got wr_n=%b addr=%0d data=%h av=%b rr=%b busy=%b idx=%0d, expected 1/0/0/0/0/0/0",
                         ifA.o_ram_wr_n, ifA.o_ram_addr, ifA.o_ram_data, ifA.o_act_valid,
                         ifA.o_res_ready, busyA, ifA.o_env_idx);
    end
    checks++;
    if (memA[576] !== 48'd1) begin
      errors++; $display("FAIL flag_kept: got %h, expected 1", memA[576]);
    end
    n = 0;
    while (busyA !== 1'b1 && n < 60) begin @(negedge clk); n++; end
    checks++;
    if (busyA !== 1'b1 || ifA.o_ram_addr !== 11'd384 || ifA.o_env_idx !== 8'd0) begin
      errors++; $display("FAIL restart_env0: got busy=%b addr=%0d idx=%0d, expected 1/384/0",
                         busyA, ifA.o_ram_addr, ifA.o_env_idx);
    end
  endtask

  task automatic test_done_pack();
    int n;
    host_wr_b(11'd576, 48'd1);
    n = 0;
    while (bdB !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    checks++;
    if (bdB !== 1'b1) begin
      errors++; $display("FAIL b_batch_done_wait: got %b, expected 1 within 3000 cycles", bdB);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (memB[1345] !== 48'hFFFF_FFFF_FFFF) begin
      errors++; $display("FAIL done_full_word: got %h, expected ffffffffffff", memB[1345]);
    end
    checks++;
    if (memB[1346] !== 48'h3) begin
      errors++; $display("FAIL done_partial_word: got %h, expected 3", memB[1346]);
    end
    checks++;
    if (memB[1347] !== 48'h0 || memB[576] !== 48'h0) begin
      errors++; $display("FAIL b_tail: got done2=%h flag=%h, expected 0 0", memB[1347], memB[576]);
    end
    checks++;
    if (bdcntB !== 1) begin
      errors++; $display("FAIL b_batch_done_pulses: got %0d, expected 1", bdcntB);
    end
  endtask

  initial begin
    ifA.i_act_ready = 1'b0; ifA.i_res_valid = 1'b0;
    ifA.i_obs = '0; ifA.i_rwd = '0; ifA.i_done = 1'b0;
    ifB.i_act_ready = 1'b1; ifB.i_res_valid = 1'b1;
    ifB.i_obs = '0; ifB.i_rwd = '0; ifB.i_done = 1'b1;
    test_reset();
    test_idle_poll();
    test_batch_env0();
    test_act_stall();
    test_batch_finish();
    test_reset_midbatch();
    test_done_pack();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
